io_pad_ctrl: RTL and testbench
==============================

// Module: io_pad_ctrl
// PURPOSE
//   Parametrised pad controller between the Caravel IO pads and the MCU IO filter.
//   Extends pad-direction control with the following:
//   - per-pin open-drain mode
//   - configurable-depth input synchronisers
//   - sticky per-pin edge-capture flags
//   - readable config registers on the wishbone multiplexer
//   Drives rst_soft_n, which is held low while programming mode is set.
// PARAMETERS
//   IO_PINS      16  MCU-visible pins
//   IO_PADS      38  Caravel pads
//   FIRST_PAD    8   pad index of pin 0; FIRST_PAD+IO_PINS <= IO_PADS
//   SYNC_STAGES  2   input synchroniser depth, >= 1
// PORTS
//   clk           in   1        single clock
//   rst_hard_n    in   1        synchronous, active-low reset
//   io_in         in   IO_PADS  pad input values
//   io_out        out  IO_PADS  pad output values
//   io_oeb        out  IO_PADS  pad output enable, active low
//   rst_soft_n    out  1        MCU soft reset, active low
//   pin_dir       out  IO_PINS  effective direction, 1 = output
//   pin_data_in   out  IO_PINS  synchronised pin input values
//   pin_data_out  in   IO_PINS  values driven by the MCU
//   cfg_we        in   1        config write strobe
//   cfg_addr      in   3        config register address
//   cfg_wdata     in   IO_PINS  config write data
//   cfg_rdata     out  IO_PINS  config read data, combinational
// BEHAVIOUR
//   Registers (cfg_addr):
//   - 0 programming: bit0 only, read/write.
//   - 1 saved_dir: read/write.
//   - 2 od_mode: read/write.
//   - 3 edge_flags: read; writing 1 clears that flag (W1C).
//   - 4 sync_in: read-only.
//   - 5-7: read as 0, writes ignored.
//   Writes land on the clk edge where cfg_we=1 and are visible from the next cycle.
//   Reset (rst_hard_n=0 at a clk edge): all registers, sync chains and prev_in go to 0.
//   - Reset takes priority over a same-cycle cfg_we.
//   - Resulting outputs: rst_soft_n=0, pin_dir=0, io_oeb all 1, io_out all 0, pin_data_in=0.
//   rst_soft_n = rst_hard_n & ~programming, combinational from the register.
//   pin_dir = rst_soft_n ? saved_dir : 0. Every pin is an input while programming or in reset.
//   Pad mapping: pin i <-> pad FIRST_PAD+i. Unmapped pads are fixed at oeb=1, out=0.
//   Push-pull pin (od_mode[i]=0):
//   - io_oeb = ~pin_dir[i].
//   - io_out = pin_dir[i] & pin_data_out[i].
//   Open-drain pin (od_mode[i]=1):
//   - io_out = 0.
//   - io_oeb = ~(pin_dir[i] & ~pin_data_out[i]); the pad is released when driving 1.
//   Synchroniser: io_in passes through SYNC_STAGES flops to give sync_in.
//   - pin_data_in[i] = sync_in[i] & ~(pin_dir[i] & ~od_mode[i]).
//   - Open-drain pins read back the pad value.
//   - Latency from a pad change to pin_data_in is SYNC_STAGES cycles.
//   Edge capture: prev_in <= sync_in every cycle.
//   - edge_flags[i] sets when sync_in[i] != prev_in[i] and pin i is not push-pull output.
//   - A flag is readable the cycle after prev_in and sync_in differ.
//   - Flags stay set until cleared by W1C.
//   - If a set and a W1C clear land on the same edge, the set wins.
//   A soft reset (programming=1) does not clear flags or od_mode; only rst_hard_n does.
// TESTING
//   1. Reset:
//      - Stimulus: hold rst_hard_n=0 for 2 clks with cfg_we=1, addr=1, wdata=FFFF.
//      - Response: saved_dir=0, io_oeb all 1, rst_soft_n=0.
//   2. Push-pull output:
//      - Stimulus: write dir=0x0001, then pin_data_out=0x0001.
//      - Response: from the next cycle, io_oeb[8]=0 and io_out[8]=1; other pads oeb=1.
//   3. Open-drain:
//      - Stimulus: dir=od=0x0002; pin_data_out[1]=0, then 1; drive io_in[9]=1 after release.
//      - Response: with data 0, io_oeb[9]=0 and io_out[9]=0; with data 1, io_oeb[9]=1.
//      - Response: pin_data_in[1]=1 SYNC_STAGES cycles after io_in[9]=1.
//   4. Synchroniser latency:
//      - Stimulus: toggle io_in[10] at cycle t.
//      - Response: pin_data_in[2] changes at t+SYNC_STAGES.
//      - Response: edge_flags[2] reads 1 at t+SYNC_STAGES+1.
//   5. W1C collision:
//      - Stimulus: write addr=3 wdata=0x0004 on the same edge a new edge is detected on pin 2.
//      - Response: flag 2 stays 1; a later W1C with no edge clears it to 0.
//   6. Programming mode:
//      - Stimulus: dir=FFFF, then write addr=0 wdata=1.
//      - Response: next cycle rst_soft_n=0, pin_dir=0, cfg_rdata at addr 1 still reads FFFF.
//      - Response: writing 0 to addr 0 restores pin_dir=FFFF.

Source files
------------

// File: rtl/io_pad_ctrl.sv
// io_pad_ctrl: pad controller sitting between the Caravel IO pads and the
// MCU IO filter. Handles pad direction, per-pin open-drain, input
// synchronisation, sticky edge capture and a small readable config bank.
module io_pad_ctrl #(
    parameter int IO_PINS     = 16,
    parameter int IO_PADS     = 38,
    parameter int FIRST_PAD   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_hard_n,
    input  logic [IO_PADS-1:0] io_in,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic               rst_soft_n,
    output logic [IO_PINS-1:0] pin_dir,
    output logic [IO_PINS-1:0] pin_data_in,
    input  logic [IO_PINS-1:0] pin_data_out,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [IO_PINS-1:0] cfg_wdata,
    output logic [IO_PINS-1:0] cfg_rdata
);

    localparam logic [2:0] ADDR_PROG  = 3'd0;
    localparam logic [2:0] ADDR_DIR   = 3'd1;
    localparam logic [2:0] ADDR_OD    = 3'd2;
    localparam logic [2:0] ADDR_FLAGS = 3'd3;
    localparam logic [2:0] ADDR_SYNC  = 3'd4;

    // Configuration state
    logic               r_programming;
    logic [IO_PINS-1:0] r_saved_dir;
    logic [IO_PINS-1:0] r_od_mode;
    logic [IO_PINS-1:0] r_edge_flags;

    // Input path state: synchroniser chain and previous synchronised value
    logic [IO_PINS-1:0] r_sync [SYNC_STAGES];
    logic [IO_PINS-1:0] r_prev_in;

    logic [IO_PINS-1:0] w_pad_in;
    logic [IO_PINS-1:0] w_sync_in;
    logic [IO_PINS-1:0] w_pp_out;
    logic [IO_PINS-1:0] w_edge;
    logic [IO_PINS-1:0] w_clear;
    logic [IO_PADS-1:0] w_unused_io;

    // Soft reset follows the hard reset and is also asserted while programming;
    // every pin falls back to input whenever soft reset is active.
    assign rst_soft_n = rst_hard_n & ~r_programming;
    assign pin_dir    = rst_soft_n ? r_saved_dir : '0;

    // A pin actively drives its own pad only when it is a push-pull output;
    // such pins neither read back the pad nor record edges.
    assign w_pp_out    = pin_dir & ~r_od_mode;
    assign w_sync_in   = r_sync[SYNC_STAGES-1];
    assign pin_data_in = w_sync_in & ~w_pp_out;
    assign w_edge      = (w_sync_in ^ r_prev_in) & ~w_pp_out;
    assign w_clear     = (cfg_we && (cfg_addr == ADDR_FLAGS)) ? cfg_wdata : '0;

    // Pad mapping: pin i lives on pad FIRST_PAD+i, every other pad is parked
    // as an undriven input. Unmapped pad inputs are collected only to mark
    // them as intentionally ignored.
    genvar gi;
    generate
        for (gi = 0; gi < IO_PADS; gi++) begin : g_pad
            if (gi >= FIRST_PAD && gi < FIRST_PAD + IO_PINS) begin : g_mapped
                localparam int P = gi - FIRST_PAD;
                // Open-drain pins never drive high: they pull low or release.
                assign io_out[gi]      = ~r_od_mode[P] & pin_dir[P] & pin_data_out[P];
                assign io_oeb[gi]      = r_od_mode[P] ? ~(pin_dir[P] & ~pin_data_out[P])
                                                      : ~pin_dir[P];
                assign w_pad_in[P]     = io_in[gi];
                assign w_unused_io[gi] = 1'b0;
            end else begin : g_fixed
                assign io_out[gi]      = 1'b0;
                assign io_oeb[gi]      = 1'b1;
                assign w_unused_io[gi] = io_in[gi];
            end
        end
    endgenerate

    // Config register writes; hard reset overrides a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            r_programming <= 1'b0;
            r_saved_dir   <= '0;
            r_od_mode     <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_PROG: r_programming <= cfg_wdata[0];
                ADDR_DIR:  r_saved_dir   <= cfg_wdata;
                ADDR_OD:   r_od_mode     <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    // Sticky edge flags: W1C clears, but a new edge on the same cycle wins
    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            r_edge_flags <= '0;
        end else begin
            r_edge_flags <= (r_edge_flags & ~w_clear) | w_edge;
        end
    end

    // Input synchroniser chain plus the one-cycle history used for edge detect
    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev_in <= '0;
        end else begin
            r_sync[0] <= w_pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev_in <= w_sync_in;
        end
    end

    // Combinational config read-back; unused addresses read as zero
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_PROG:  cfg_rdata = {{(IO_PINS-1){1'b0}}, r_programming};
            ADDR_DIR:   cfg_rdata = r_saved_dir;
            ADDR_OD:    cfg_rdata = r_od_mode;
            ADDR_FLAGS: cfg_rdata = r_edge_flags;
            ADDR_SYNC:  cfg_rdata = w_sync_in;
            default:    cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Testbench for io_pad_ctrl: scenario tasks push expected values into a
// scoreboard queue as stimulus is applied, then pop and compare them once
// the DUT has produced the corresponding output.
module tb_io_pad_ctrl;

    localparam int IO_PINS     = 16;
    localparam int IO_PADS     = 38;
    localparam int FIRST_PAD   = 8;
    localparam int SYNC_STAGES = 2;
    localparam logic [IO_PADS-1:0] OEB_ALL = '1;

    logic               clk;
    logic               rst_hard_n;
    logic [IO_PADS-1:0] io_in;
    logic [IO_PADS-1:0] io_out;
    logic [IO_PADS-1:0] io_oeb;
    logic               rst_soft_n;
    logic [IO_PINS-1:0] pin_dir;
    logic [IO_PINS-1:0] pin_data_in;
    logic [IO_PINS-1:0] pin_data_out;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [IO_PINS-1:0] cfg_wdata;
    logic [IO_PINS-1:0] cfg_rdata;

    int          total;
    int          bad;
    logic [63:0] sb_q[$];
    logic [63:0] obs;
    logic [63:0] exp_v;
    logic [15:0] rd;

    io_pad_ctrl #(
        .IO_PINS(IO_PINS), .IO_PADS(IO_PADS),
        .FIRST_PAD(FIRST_PAD), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_hard_n(rst_hard_n), .io_in(io_in), .io_out(io_out),
        .io_oeb(io_oeb), .rst_soft_n(rst_soft_n), .pin_dir(pin_dir),
        .pin_data_in(pin_data_in), .pin_data_out(pin_data_out), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        $display("cfg write addr=%0d data=%h", a, d);
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [15:0] v);
        cfg_addr = a;
        #1;
        v = cfg_rdata;
        $display("cfg read  addr=%0d data=%h", a, v);
    endtask

    task automatic test_reset();
        rst_hard_n = 1'b0; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'hFFFF;
        sb_q.push_back(64'd0);            // rst_soft_n
        sb_q.push_back(64'(OEB_ALL));     // io_oeb
        sb_q.push_back(64'd0);            // io_out
        sb_q.push_back(64'd0);            // pin_dir
        sb_q.push_back(64'd0);            // pin_data_in
        sb_q.push_back(64'd0);            // saved_dir
        sb_q.push_back(64'd1);            // rst_soft_n after release
        tick(); tick();
        exp_v = sb_q.pop_front(); obs = 64'(rst_soft_n); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_soft_n: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_oeb: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_out: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_dir: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_din: got %h want %h", obs, exp_v); end
        cfg_we = 1'b0; rst_hard_n = 1'b1;
        cfg_read(3'd1, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_saved_dir: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(rst_soft_n); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
        $display("test_reset done");
    endtask

    task automatic test_push_pull();
        cfg_write(3'd1, 16'h0001);
        pin_data_out = 16'h0001;
        sb_q.push_back(64'(OEB_ALL & ~(38'd1 << 8)));
        sb_q.push_back(64'(38'd1 << 8));
        sb_q.push_back(64'h1);
        #1;
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_oeb: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_out_high: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_dir: got %h want %h", obs, exp_v); end
        pin_data_out = 16'h0000;
        sb_q.push_back(64'd0);
        #1;
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_out_low: got %h want %h", obs, exp_v); end
        $display("test_push_pull done");
    endtask

    task automatic test_open_drain();
        cfg_write(3'd1, 16'h0002);
        cfg_write(3'd2, 16'h0002);
        sb_q.push_back(64'(OEB_ALL & ~(38'd1 << 9)));
        sb_q.push_back(64'd0);
        #1;
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_low_oeb: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_low_out: got %h want %h", obs, exp_v); end
        pin_data_out = 16'h0002;
        sb_q.push_back(64'(OEB_ALL));
        sb_q.push_back(64'd0);
        #1;
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_release_oeb: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_release_out: got %h want %h", obs, exp_v); end
        io_in[9] = 1'b1;
        sb_q.push_back(64'h0000);  // one cycle after: not yet through
        sb_q.push_back(64'h0002);  // SYNC_STAGES cycles after
        sb_q.push_back(64'h0002);  // flag one cycle later
        tick();
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_readback_early: got %h want %h", obs, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_readback: got %h want %h", obs, exp_v); end
        tick();
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_edge_flag: got %h want %h", obs, exp_v); end
        io_in[9] = 1'b0;
        tick(); tick(); tick();
        cfg_write(3'd3, 16'hFFFF);
        sb_q.push_back(64'd0);
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL od_flags_cleared: got %h want %h", obs, exp_v); end
        $display("test_open_drain done");
    endtask

    task automatic test_sync_latency();
        cfg_write(3'd2, 16'h0000);
        cfg_write(3'd1, 16'h0000);
        io_in[10] = 1'b1;
        sb_q.push_back(64'h0000);
        sb_q.push_back(64'h0004);
        sb_q.push_back(64'h0000);
        sb_q.push_back(64'h0004);
        tick();
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sync_t1: got %h want %h", obs, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sync_t2: got %h want %h", obs, exp_v); end
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sync_flag_early: got %h want %h", obs, exp_v); end
        tick();
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sync_flag: got %h want %h", obs, exp_v); end
        $display("test_sync_latency done");
    endtask

    task automatic test_w1c_collision();
        io_in[10] = 1'b0;
        tick(); tick();
        // Third edge after the change is the one that detects it
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'h0004;
        sb_q.push_back(64'h0004);
        sb_q.push_back(64'h0000);
        tick();
        cfg_we = 1'b0;
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL w1c_set_wins: got %h want %h", obs, exp_v); end
        cfg_write(3'd3, 16'h0004);
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL w1c_clear: got %h want %h", obs, exp_v); end
        $display("test_w1c_collision done");
    endtask

    task automatic test_pp_mask();
        cfg_write(3'd1, 16'h0008);
        io_in[11] = 1'b1;
        sb_q.push_back(64'h0000);  // no flag for push-pull output
        sb_q.push_back(64'h0008);  // sync_in still sees the pad
        sb_q.push_back(64'h0000);  // pin_data_in masked
        sb_q.push_back(64'h0008);  // unmasked once an input
        tick(); tick(); tick(); tick();
        cfg_read(3'd3, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_no_flag: got %h want %h", obs, exp_v); end
        cfg_read(3'd4, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_sync_in: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_din_masked: got %h want %h", obs, exp_v); end
        cfg_write(3'd1, 16'h0000);
        exp_v = sb_q.pop_front(); obs = 64'(pin_data_in); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL pp_din_unmasked: got %h want %h", obs, exp_v); end
        $display("test_pp_mask done");
    endtask

    task automatic test_regs();
        cfg_write(3'd0, 16'hFFFE);
        sb_q.push_back(64'h0);
        cfg_read(3'd0, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_bit0_only: got %h want %h", obs, exp_v); end
        for (int a = 5; a < 8; a++) begin
            cfg_write(3'(a), 16'hFFFF);
            sb_q.push_back(64'h0);
            cfg_read(3'(a), rd);
            exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL unused_addr%0d: got %h want %h", a, obs, exp_v); end
        end
        cfg_write(3'd4, 16'h0000);
        sb_q.push_back(64'h0008);
        cfg_read(3'd4, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sync_read_only: got %h want %h", obs, exp_v); end
        $display("test_regs done");
    endtask

    task automatic test_programming();
        cfg_write(3'd2, 16'h00F0);
        cfg_write(3'd1, 16'hFFFF);
        sb_q.push_back(64'hFFFF);
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_dir_before: got %h want %h", obs, exp_v); end
        cfg_write(3'd0, 16'h0001);
        sb_q.push_back(64'd0);
        sb_q.push_back(64'd0);
        sb_q.push_back(64'(OEB_ALL));
        sb_q.push_back(64'hFFFF);
        sb_q.push_back(64'h00F0);
        exp_v = sb_q.pop_front(); obs = 64'(rst_soft_n); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_soft_n: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_dir: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_oeb: got %h want %h", obs, exp_v); end
        cfg_read(3'd1, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_saved_dir: got %h want %h", obs, exp_v); end
        cfg_read(3'd2, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_od_kept: got %h want %h", obs, exp_v); end
        cfg_write(3'd0, 16'h0000);
        // pin_data_out = 0x0002: pin1 push-pull high, od pins 4..7 pull low
        sb_q.push_back(64'hFFFF);
        sb_q.push_back(64'd1);
        sb_q.push_back(64'(OEB_ALL & ~(38'hFFFF << 8)));
        sb_q.push_back(64'(38'd1 << 9));
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_dir_restored: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(rst_soft_n); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL prog_soft_n_restored: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_oeb); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mixed_oeb: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(io_out); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mixed_out: got %h want %h", obs, exp_v); end
        $display("test_programming done");
    endtask

    task automatic test_hard_reset();
        rst_hard_n = 1'b0;
        tick();
        rst_hard_n = 1'b1;
        sb_q.push_back(64'h0);
        sb_q.push_back(64'h0);
        sb_q.push_back(64'h0);
        cfg_read(3'd2, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hrst_od: got %h want %h", obs, exp_v); end
        cfg_read(3'd4, rd);
        exp_v = sb_q.pop_front(); obs = 64'(rd); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hrst_sync: got %h want %h", obs, exp_v); end
        exp_v = sb_q.pop_front(); obs = 64'(pin_dir); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hrst_dir: got %h want %h", obs, exp_v); end
        $display("test_hard_reset done");
    endtask

    initial begin
        total = 0; bad = 0;
        rst_hard_n = 1'b0; io_in = '0; pin_data_out = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #1;
        test_reset();
        test_push_pull();
        test_open_drain();
        test_sync_latency();
        test_w1c_collision();
        test_pp_mask();
        test_regs();
        test_programming();
        test_hard_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
